// File: rtl/sys_tohost_slv.sv
// AXI4-Lite 64-bit system-channel slave: tohost mailbox, console byte FIFO, status and cycle counter.
// Lets a simulation harness end the run from the software's own tohost write.
module sys_tohost_slv #(
  parameter logic [31:0] BASE    = 32'h2000_0000,
  parameter int unsigned FIFO_DP = 16,
  parameter logic [63:0] TIMEOUT = 64'd500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sys_aw_valid,
  output logic        sys_aw_ready,
  input  logic [31:0] sys_aw_addr,
  input  logic        sys_w_valid,
  output logic        sys_w_ready,
  input  logic [63:0] sys_w_data,
  input  logic [7:0]  sys_w_strb,
  output logic        sys_b_valid,
  input  logic        sys_b_ready,
  output logic [1:0]  sys_b_rsp,
  input  logic        sys_ar_valid,
  output logic        sys_ar_ready,
  input  logic [31:0] sys_ar_addr,
  output logic        sys_r_valid,
  input  logic        sys_r_ready,
  output logic [63:0] sys_r_data,
  output logic [1:0]  sys_r_rsp,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [7:0]  char_data,
  output logic        done,
  output logic        pass,
  output logic [62:0] exit_code,
  output logic        timeout
);

  localparam int unsigned AW = $clog2(FIFO_DP);
  localparam int unsigned PW = AW + 1;
  localparam logic [1:0] RspOkay   = 2'b00;
  localparam logic [1:0] RspSlverr = 2'b10;

  // Returns {hit, register index}; misses cover out-of-window and unaligned offsets.
  function automatic logic [2:0] decode(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    return {(off[31:5] == 27'd0) && (off[2:0] == 3'd0), off[4:3]};
  endfunction

  // Write channel state
  logic        aw_held_q, w_held_q, w_strb0_q;
  logic [31:0] aw_addr_q;
  logic [63:0] w_data_q;
  logic        b_valid_q;
  logic [1:0]  b_rsp_q;

  // Read channel state
  logic        r_valid_q;
  logic [63:0] r_data_q;
  logic [1:0]  r_rsp_q;

  // Register file state
  logic        done_q, pass_q, timeout_q, overflow_q;
  logic [62:0] exit_code_q;
  logic [63:0] cnt_q;

  // Console FIFO
  logic [7:0]    mem_q [FIFO_DP];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic          fifo_empty, fifo_full, push, pop, push_ok, ovf_set;

  logic        aw_hs, w_hs, ar_hs, wr_fire, wr_strb0, tohost_we, status_clr;
  logic [31:0] wr_addr;
  logic [63:0] wr_data, rd_data_d, status_word;
  logic [2:0]  wr_dec, rd_dec;
  logic [1:0]  rd_rsp_d;
  logic [7:0]  cnt8;
  logic        unused_strb;

  assign unused_strb = ^sys_w_strb[7:1];

  assign sys_aw_ready = !aw_held_q && !b_valid_q && !reset;
  assign sys_w_ready  = !w_held_q && !b_valid_q && !reset;
  assign sys_ar_ready = !r_valid_q && !reset;

  assign aw_hs = sys_aw_valid && sys_aw_ready;
  assign w_hs  = sys_w_valid && sys_w_ready;
  assign ar_hs = sys_ar_valid && sys_ar_ready;

  // A fresh beat on either channel is used directly so a same-cycle capture completes at once.
  assign wr_addr  = aw_held_q ? aw_addr_q : sys_aw_addr;
  assign wr_data  = w_held_q ? w_data_q : sys_w_data;
  assign wr_strb0 = w_held_q ? w_strb0_q : sys_w_strb[0];
  assign wr_fire  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !b_valid_q;
  assign wr_dec   = decode(wr_addr);

  assign tohost_we = wr_fire && wr_dec[2] && (wr_dec[1:0] == 2'd0) && wr_strb0 &&
                     !done_q && wr_data[0];
  assign push      = wr_fire && wr_dec[2] && (wr_dec[1:0] == 2'd1) && wr_strb0;

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == PW'(FIFO_DP));
  assign pop        = !fifo_empty && char_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign ovf_set    = push && fifo_full && !pop;
  assign cnt8       = 8'(fifo_cnt);

  assign rd_dec      = decode(sys_ar_addr);
  assign status_clr  = ar_hs && rd_dec[2] && (rd_dec[1:0] == 2'd2);
  assign status_word = {48'd0, cnt8, 2'b00, fifo_empty, fifo_full, overflow_q, timeout_q,
                        pass_q, done_q};

  always_comb begin
    rd_data_d = '0;
    rd_rsp_d  = RspSlverr;
    if (rd_dec[2]) begin
      rd_rsp_d = RspOkay;
      unique case (rd_dec[1:0])
        2'd0:    rd_data_d = {exit_code_q, done_q};
        2'd1:    rd_data_d = '0;
        2'd2:    rd_data_d = status_word;
        default: rd_data_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb0_q <= 1'b0;
      b_valid_q <= 1'b0;
      b_rsp_q   <= RspOkay;
    end else begin
      if (wr_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        b_valid_q <= 1'b1;
        b_rsp_q   <= wr_dec[2] ? RspOkay : RspSlverr;
      end else begin
        if (aw_hs) begin
          aw_held_q <= 1'b1;
          aw_addr_q <= sys_aw_addr;
        end
        if (w_hs) begin
          w_held_q  <= 1'b1;
          w_data_q  <= sys_w_data;
          w_strb0_q <= sys_w_strb[0];
        end
        if (b_valid_q && sys_b_ready) b_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_rsp_q   <= RspOkay;
    end else if (ar_hs) begin
      r_valid_q <= 1'b1;
      r_data_q  <= rd_data_d;
      r_rsp_q   <= rd_rsp_d;
    end else if (sys_r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      exit_code_q <= '0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 64'd1;
      if (tohost_we) begin
        done_q      <= 1'b1;
        pass_q      <= (wr_data == 64'd1);
        exit_code_q <= wr_data[63:1];
      end
      if ((TIMEOUT != 64'd0) && (cnt_q == TIMEOUT - 64'd1) && !done_q) timeout_q <= 1'b1;
      // A drop in the same cycle as a STATUS read keeps the flag set.
      if (ovf_set)         overflow_q <= 1'b1;
      else if (status_clr) overflow_q <= 1'b0;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data[7:0];
  end

  assign sys_b_valid = b_valid_q;
  assign sys_b_rsp   = b_rsp_q;
  assign sys_r_valid = r_valid_q;
  assign sys_r_data  = r_data_q;
  assign sys_r_rsp   = r_rsp_q;
  assign char_valid  = !fifo_empty;
  assign char_data   = mem_q[rd_ptr_q[AW-1:0]];
  assign done        = done_q;
  assign pass        = pass_q;
  assign exit_code   = exit_code_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_sys_tohost_slv.sv
// Directed bench for sys_tohost_slv: a register-access vector table plus scripted
// sequences for channel ordering, console FIFO overflow, timeout and mid-stall reset.
module tb_sys_tohost_slv;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sys_aw_valid = 1'b0, sys_aw_ready;
  logic [31:0] sys_aw_addr = '0;
  logic        sys_w_valid = 1'b0, sys_w_ready;
  logic [63:0] sys_w_data = '0;
  logic [7:0]  sys_w_strb = '0;
  logic        sys_b_valid, sys_b_ready = 1'b0;
  logic [1:0]  sys_b_rsp;
  logic        sys_ar_valid = 1'b0, sys_ar_ready;
  logic [31:0] sys_ar_addr = '0;
  logic        sys_r_valid, sys_r_ready = 1'b0;
  logic [63:0] sys_r_data;
  logic [1:0]  sys_r_rsp;
  logic        char_valid, char_ready = 1'b0;
  logic [7:0]  char_data;
  logic        done, pass, timeout;
  logic [62:0] exit_code;

  int errors = 0;
  int checks = 0;
  logic [63:0] tb_cnt;

  sys_tohost_slv #(.BASE(BASE), .FIFO_DP(16), .TIMEOUT(64'd100)) dut (
    .clock(clock), .reset(reset),
    .sys_aw_valid(sys_aw_valid), .sys_aw_ready(sys_aw_ready), .sys_aw_addr(sys_aw_addr),
    .sys_w_valid(sys_w_valid), .sys_w_ready(sys_w_ready), .sys_w_data(sys_w_data),
    .sys_w_strb(sys_w_strb), .sys_b_valid(sys_b_valid), .sys_b_ready(sys_b_ready),
    .sys_b_rsp(sys_b_rsp), .sys_ar_valid(sys_ar_valid), .sys_ar_ready(sys_ar_ready),
    .sys_ar_addr(sys_ar_addr), .sys_r_valid(sys_r_valid), .sys_r_ready(sys_r_ready),
    .sys_r_data(sys_r_data), .sys_r_rsp(sys_r_rsp), .char_valid(char_valid),
    .char_ready(char_ready), .char_data(char_data), .done(done), .pass(pass),
    .exit_code(exit_code), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Reference cycle count: equals the expected DUT counter when sampled between edges.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_cnt <= '0;
    else       tb_cnt <= tb_cnt + 64'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    sys_aw_valid = 1'b0; sys_w_valid = 1'b0; sys_ar_valid = 1'b0;
    sys_b_ready = 1'b0; sys_r_ready = 1'b0; char_ready = 1'b0;
    #1;
    chk("reset_outputs", {55'd0, sys_aw_ready, sys_w_ready, sys_ar_ready, sys_b_valid,
                          sys_r_valid, char_valid, done, pass, timeout}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Called at a negedge; AW is offered from cycle aw_at and W from cycle w_at.
  task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, input int aw_at, input int w_at,
                          output logic [1:0] rsp);
    bit aw_done, w_done, hs_aw, hs_w;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    sys_aw_addr = addr; sys_w_data = data; sys_w_strb = strb;
    while (!(aw_done && w_done) && cyc < 100) begin
      sys_aw_valid = !aw_done && (cyc >= aw_at);
      sys_w_valid  = !w_done && (cyc >= w_at);
      hs_aw = sys_aw_valid && sys_aw_ready;
      hs_w  = sys_w_valid && sys_w_ready;
      @(posedge clock);
      aw_done = aw_done || hs_aw;
      w_done  = w_done || hs_w;
      cyc++;
      @(negedge clock);
    end
    sys_aw_valid = 1'b0; sys_w_valid = 1'b0;
    chk("b_latency", {63'd0, sys_b_valid}, 64'd1);
    rsp = sys_b_rsp;
    sys_b_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sys_b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [1:0] rsp,
                         output logic [63:0] data, output logic [63:0] snap);
    int cyc;
    cyc = 0;
    sys_ar_addr = addr; sys_ar_valid = 1'b1;
    while (!sys_ar_ready && cyc < 100) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
    end
    snap = tb_cnt;
    @(posedge clock);
    @(negedge clock);
    sys_ar_valid = 1'b0;
    chk("r_latency", {63'd0, sys_r_valid}, 64'd1);
    data = sys_r_data; rsp = sys_r_rsp;
    sys_r_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    sys_r_ready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_rsp;
    logic [63:0] exp_rdata;
    logic [63:0] rmask;
    string       name;
  } vec_t;

  vec_t vecs[19];

  initial begin
    logic [1:0]  rsp;
    logic [63:0] rd, snap, mask_st;
    mask_st = ~64'h4;

    vecs[0]  = '{0, BASE + 32'h10, 64'h0,  8'h00, 2'b00, 64'h20,  mask_st, "status_reset"};
    vecs[1]  = '{1, BASE + 32'h04, 64'h1,  8'hFF, 2'b10, 64'h0,   64'h0,   "wr_unaligned"};
    vecs[2]  = '{0, BASE + 32'h20, 64'h0,  8'h00, 2'b10, 64'h0,   ~64'h0,  "rd_off_20"};
    vecs[3]  = '{0, BASE + 32'h03, 64'h0,  8'h00, 2'b10, 64'h0,   ~64'h0,  "rd_unaligned"};
    vecs[4]  = '{1, BASE,          64'h0,  8'hFF, 2'b00, 64'h0,   64'h0,   "wr_tohost_even"};
    vecs[5]  = '{0, BASE,          64'h0,  8'h00, 2'b00, 64'h0,   ~64'h0,  "rd_tohost_idle"};
    vecs[6]  = '{1, BASE,          64'h7,  8'hFE, 2'b00, 64'h0,   64'h0,   "wr_tohost_nostrb"};
    vecs[7]  = '{0, BASE,          64'h0,  8'h00, 2'b00, 64'h0,   ~64'h0,  "rd_tohost_idle2"};
    vecs[8]  = '{1, BASE + 32'h08, 64'h78, 8'h01, 2'b00, 64'h0,   64'h0,   "wr_console"};
    vecs[9]  = '{0, BASE + 32'h10, 64'h0,  8'h00, 2'b00, 64'h100, mask_st, "status_one"};
    vecs[10] = '{0, BASE + 32'h08, 64'h0,  8'h00, 2'b00, 64'h0,   ~64'h0,  "rd_console"};
    vecs[11] = '{1, BASE + 32'h10, 64'hFF, 8'hFF, 2'b00, 64'h0,   64'h0,   "wr_status"};
    vecs[12] = '{1, BASE + 32'h18, 64'hFF, 8'hFF, 2'b00, 64'h0,   64'h0,   "wr_cycle"};
    vecs[13] = '{1, BASE,          64'h7,  8'hFF, 2'b00, 64'h0,   64'h0,   "wr_tohost_7"};
    vecs[14] = '{0, BASE,          64'h0,  8'h00, 2'b00, 64'h7,   ~64'h0,  "rd_tohost_7"};
    vecs[15] = '{0, BASE + 32'h10, 64'h0,  8'h00, 2'b00, 64'h101, mask_st, "status_done"};
    vecs[16] = '{1, BASE,          64'h1,  8'hFF, 2'b00, 64'h0,   64'h0,   "wr_tohost_late"};
    vecs[17] = '{0, BASE,          64'h0,  8'h00, 2'b00, 64'h7,   ~64'h0,  "rd_tohost_kept"};
    vecs[18] = '{1, BASE - 32'h8,  64'h1,  8'hFF, 2'b10, 64'h0,   64'h0,   "wr_below_base"};

    // Register access table
    apply_reset();
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, rsp);
        chk({vecs[i].name, "_rsp"}, {62'd0, rsp}, {62'd0, vecs[i].exp_rsp});
      end else begin
        do_read(vecs[i].addr, rsp, rd, snap);
        chk({vecs[i].name, "_rsp"}, {62'd0, rsp}, {62'd0, vecs[i].exp_rsp});
        chk({vecs[i].name, "_data"}, rd & vecs[i].rmask, vecs[i].exp_rdata);
      end
    end
    chk("console_head", {55'd0, char_valid, char_data}, {55'd0, 1'b1, 8'h78});

    // AW at cycle 0, W at cycle 3, passing tohost
    apply_reset();
    do_write(BASE, 64'd1, 8'hFF, 0, 3, rsp);
    chk("pass_rsp", {62'd0, rsp}, 64'd0);
    chk("pass_flags", {exit_code, done, pass}, {63'd0, 1'b1, 1'b1});

    // Same-cycle failing tohost, then a W-before-AW write that must be ignored
    apply_reset();
    do_write(BASE, 64'd7, 8'hFF, 0, 0, rsp);
    chk("fail_rsp", {62'd0, rsp}, 64'd0);
    do_write(BASE, 64'd1, 8'hFF, 2, 0, rsp);
    chk("second_rsp", {62'd0, rsp}, 64'd0);
    chk("fail_flags", {exit_code, done, pass}, {63'd3, 1'b1, 1'b0});

    // Console overflow, overflow clear on read, then ordered drain
    apply_reset();
    for (int i = 0; i < 17; i++) do_write(BASE + 32'h08, 64'(8'h41 + i), 8'h01, 0, 0, rsp);
    chk("ovf_wr_rsp", {62'd0, rsp}, 64'd0);
    do_read(BASE + 32'h10, rsp, rd, snap);
    chk("status_full", rd & 64'hFF38, 64'h1018);
    do_read(BASE + 32'h10, rsp, rd, snap);
    chk("status_ovf_clr", rd & 64'hFF38, 64'h1010);
    char_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_byte", {55'd0, char_valid, char_data}, {55'd0, 1'b1, 8'(8'h41 + i)});
      @(posedge clock);
      @(negedge clock);
    end
    chk("drain_empty", {63'd0, char_valid}, 64'd0);
    char_ready = 1'b0;

    // Push into a full FIFO in the same cycle as a pop
    for (int i = 0; i < 16; i++) do_write(BASE + 32'h08, 64'(8'h41 + i), 8'h01, 0, 0, rsp);
    char_ready = 1'b1;
    do_write(BASE + 32'h08, 64'h5A, 8'h01, 0, 0, rsp);
    char_ready = 1'b0;
    do_read(BASE + 32'h10, rsp, rd, snap);
    chk("full_pushpop", rd & 64'hFF38, 64'h0F00);
    char_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("pushpop_byte", {56'd0, char_data}, (i < 14) ? 64'(8'h43 + i) : 64'h5A);
      @(posedge clock);
      @(negedge clock);
    end
    char_ready = 1'b0;

    // Timeout at counter 99, then a CYCLE read
    apply_reset();
    repeat (99) @(negedge clock);
    chk("timeout_before", {63'd0, timeout}, 64'd0);
    @(negedge clock);
    chk("timeout_set", {63'd0, timeout}, 64'd1);
    repeat (5) @(negedge clock);
    do_read(BASE + 32'h18, rsp, rd, snap);
    chk("cycle_rsp", {62'd0, rsp}, 64'd0);
    chk("cycle_value", rd, snap);
    chk("cycle_ge_100", {63'd0, rd >= 64'd100}, 64'd1);

    // B stall holds both write readies low; reset mid-stall clears everything
    apply_reset();
    do_write(BASE, 64'd1, 8'hFF, 0, 0, rsp);
    sys_aw_addr = BASE + 32'h08; sys_w_data = 64'h53; sys_w_strb = 8'h01;
    sys_aw_valid = 1'b1; sys_w_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready", {61'd0, sys_aw_ready, sys_w_ready, sys_b_valid}, 64'd1);
      @(posedge clock);
      @(negedge clock);
    end
    chk("stall_state", {62'd0, char_valid, done}, 64'd3);
    reset = 1'b1;
    sys_aw_valid = 1'b0; sys_w_valid = 1'b0;
    #1;
    chk("midreset", {61'd0, sys_b_valid, char_valid, done}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    do_read(BASE + 32'h18, rsp, rd, snap);
    chk("cycle_restart", rd, snap);
    chk("cycle_small", {63'd0, rd < 64'd10}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
